// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg
//   Shared definitions for the programmable counter: mode encodings and
//   the run-control FSM state type.
package prog_counter_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;
   // 2'b11 is not named; the counter treats it as wrap.

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } pc_state_t;

endpackage

// File: rtl/prog_prescaler.sv
// prog_prescaler
//   Clock prescaler producing a single-cycle tick every presc+1 enabled cycles.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     clr        : synchronous restart of the prescale count (wins over cnt_en)
//     cnt_en     : advance the prescale count this cycle
//     presc      : divide value, tick every presc+1 enabled cycles
//     tick       : combinational, high in the cycle the count equals presc
module prog_prescaler #(
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               cnt_en,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   localparam logic [PRESC_W-1:0] PSC_ONE = PRESC_W'(1);

   logic [PRESC_W-1:0] psc_q;

   // >= rather than == so that lowering presc below the current count mid-run
   // ticks promptly instead of waiting for the count to roll over.
   assign tick = cnt_en && (psc_q >= presc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_q <= '0;
      end else if (clr || tick) begin
         psc_q <= '0;
      end else if (cnt_en) begin
         psc_q <= psc_q + PSC_ONE;
      end
   end

endmodule

// File: rtl/prog_counter.sv
// prog_counter
//   Programmable up/down counter with prescaler, wrap/saturate/one-shot modes,
//   terminal-count pulse and compare match. All outputs registered.
//   Ports:
//     clk, rst_n        : clock, async active-low reset
//     en                : run enable (low holds count, clears prescaler)
//     clr, load         : synchronous clear / load (clr wins), any state
//     load_val          : value for load
//     dir               : 0 up, 1 down
//     mode              : 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//     presc             : tick every presc+1 cycles while running
//     cmp_val           : compare value for match
//     count             : current count
//     tc                : one-cycle pulse when count first reaches terminal by a tick
//     match             : count == cmp_val
//     running, done     : FSM in RUN / DONE
//
//   state | meaning
//   IDLE  | stopped, waiting for en
//   RUN   | prescaler active, count advances on tick
//   DONE  | one-shot reached terminal; waits for clr or load
module prog_counter
   import prog_counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               clr,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   input  logic               dir,
   input  logic [1:0]         mode,
   input  logic [PRESC_W-1:0] presc,
   input  logic [WIDTH-1:0]   cmp_val,
   output logic [WIDTH-1:0]   count,
   output logic               tc,
   output logic               match,
   output logic               running,
   output logic               done
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   pc_state_t        state_q, state_n;
   logic [WIDTH-1:0] count_q, count_n;
   logic [WIDTH-1:0] term, count_step;
   logic             tc_q, tc_n, match_q;
   logic             tick, psc_clr, psc_en;
   logic             at_term, os_finish;

   assign psc_en  = (state_q == RUN) && en;
   assign psc_clr = clr || load || !en || (state_q != RUN);

   prog_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (psc_clr),
      .cnt_en (psc_en),
      .presc  (presc),
      .tick   (tick)
   );

   assign term       = dir ? '0 : '1;
   assign at_term    = (count_q == term);
   assign count_step = dir ? (count_q - CNT_ONE) : (count_q + CNT_ONE);

   always_comb begin
      count_n   = count_q;
      tc_n      = 1'b0;
      os_finish = 1'b0;
      if (clr) begin
         count_n = '0;
      end else if (load) begin
         count_n = load_val;
      end else if (tick) begin
         unique case (mode)
            MODE_SAT: begin
               if (!at_term) count_n = count_step;
            end
            MODE_ONESHOT: begin
               // Already at terminal (e.g. loaded there): finish without stepping.
               if (!at_term) count_n = count_step;
               os_finish = 1'b1;
            end
            default: count_n = count_step;
         endcase
         tc_n = !at_term && (count_n == term);
         if (count_n != term) os_finish = 1'b0;
      end
   end

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         IDLE: if (en) state_n = RUN;
         RUN: begin
            if (!en)            state_n = IDLE;
            else if (os_finish) state_n = DONE;
         end
         DONE: if (clr || load) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         tc_q    <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_n;
         count_q <= count_n;
         tc_q    <= tc_n;
         match_q <= (count_n == cmp_val);
      end
   end

   assign count   = count_q;
   assign tc      = tc_q;
   assign match   = match_q;
   assign running = (state_q == RUN);
   assign done    = (state_q == DONE);

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised programmable counter, successor to the fixed 8-bit free-run/hold counter on the Tiny Tapeout user tile. Adds configurable width, up/down direction, synchronous load and clear, a clock prescaler, wrap/saturate/one-shot modes, terminal-count pulse and compare-match output. It sits between the tile's dedicated inputs (control) and `uo_out` (count), driven by the tile clock.

## Interface
- `WIDTH`, 8: count register width (≥2).
- `PRESC_W`, 4: prescaler divide-value width (≥1).
- `clk` in 1: tile clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `en` in 1: run enable; low holds count and clears prescaler.
- `clr` in 1: synchronous clear to 0.
- `load` in 1: synchronous load of `load_val`.
- `load_val` in WIDTH: load value.
- `dir` in 1: 0 = up, 1 = down.
- `mode` in 2: 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- `presc` in PRESC_W: tick every `presc`+1 cycles.
- `cmp_val` in WIDTH: compare value.
- `count` out WIDTH: current count.
- `tc` out 1: one-cycle terminal-count pulse.
- `match` out 1: level, `count == cmp_val`.
- `running` out 1: FSM in RUN.
- `done` out 1: FSM in DONE (one-shot finished).

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
- IDLE→RUN: `en`=1. RUN→IDLE: `en`=0. RUN→DONE: one-shot tick reaching terminal. DONE→IDLE: `clr` or `load`. DONE ignores `en`.
- Terminal value: all-ones when up, 0 when down (uses current `dir`).
- Prescaler: counts only in RUN; `tick` when prescaler == `presc`, then wraps to 0. Cleared on `en`=0, `clr`, `load`, leaving RUN.
- Priority per cycle: `clr` > `load` > tick. `clr`/`load` act in any state, including with `en`=0.
- Tick, wrap: count ±1 modulo 2^WIDTH. Saturate: count ±1, held at terminal. One-shot: count ±1; on reaching terminal go DONE, further ticks ignored.
- `tc` asserts for exactly one cycle, coincident with `count` first becoming terminal via a tick. Never from `load`/`clr`. Saturate: no re-pulse while held. Wrap: pulses every pass.
- `match` registered from next-count; valid in same cycle as `count`.
- `dir`/`mode`/`presc` changes mid-run take effect on the next tick; no glitch in `count`.
- Width arithmetic: all count math at WIDTH bits, no sign extension; `presc` compare unsigned.

## Timing
- Reset values: `count`=0, `tc`=0, `match`=0, `running`=0, `done`=0, prescaler 0.
- `rst_n` deassert → first active edge may leave IDLE if `en`=1.
- `en` high at edge k → RUN after k; with `presc`=P, first count change at edge k+P+1, then every P+1 edges.
- `clr`/`load` at edge k → `count` updated after k (1-cycle latency); prescaler restarts, so next tick P+1 edges later.
- `tc`, `match`, `running`, `done` all registered; no combinational input→output path.
- `rst_n` low mid-operation: immediate return to reset values regardless of clock.

## Structure
- Package `prog_counter_pkg`: mode encoding constants (WRAP, SAT, ONESHOT), FSM state enum (IDLE, RUN, DONE).
- Sub-module `prog_prescaler` (PRESC_W parameter; inputs `clk`, `rst_n`, `clr`, `cnt_en`, `presc`; output `tick`). Count, FSM, tc/match logic in top.

## Test plan
- Reset, WIDTH=8, `en`=1, up, wrap, `presc`=0: `count` 0,1,2…255,0; `tc` high only in cycle `count`=255; `running`=1.
- `presc`=3, up: `count` changes every 4 cycles; drop `en` mid-run → `count` holds, `running`=0; re-raise → next change 4 edges later.
- Saturate, down, `load` 3: `count` 3,2,1,0,0,0; `tc` single pulse at 0; `load` 0 with saturate gives no `tc`.
- One-shot, up, `load` 250: counts to 255, `done`=1, `running`=0, further ticks hold 255; `clr` → `count`=0, IDLE, then RUN.
- `clr`, `load` and tick in same cycle → `count`=0; `load` and tick → `count`=`load_val`; `cmp_val`=5 → `match` high only while `count`=5.
- Assert `rst_n` low asynchronously mid-count (`count`=0x7A) → all outputs reset without clock edge.
